serv_mem_arbiter: RTL and testbench

//  Registered two-master Wishbone arbiter that shares one single-ported memory between the SERV ibus and dbus.

---
 rtl/serv_mem_arbiter_pkg.sv | 18 +
 rtl/serv_arb_timeout.sv | 30 +++
 rtl/serv_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_serv_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_mem_arbiter_pkg.sv
// rtl/serv_mem_arbiter_pkg.sv - shared types and constants for the SERV ibus/dbus memory arbiter
package serv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic {
        M_IBUS = 1'b0,
        M_DBUS = 1'b1
    } master_t;

    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/serv_arb_timeout.sv
// rtl/serv_arb_timeout.sv - clear/enable/saturate bus timeout counter
// Expires in the cycle whose increment would bring the count to all-ones.
module serv_arb_timeout #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [W-1:0] CNT_LAST = CNT_MAX - 1'b1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/serv_mem_arbiter.sv
// rtl/serv_mem_arbiter.sv - registered two-master Wishbone arbiter sharing one memory port
// between the SERV ibus and dbus, with alternating priority, a release cycle and bus timeout.
module serv_mem_arbiter
    import serv_mem_arbiter_pkg::*;
#(
    parameter int TMO_W      = 8,
    parameter bit DBUS_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    output logic [3:0]  o_mem_sel,
    output logic        o_mem_we,
    output logic        o_mem_cyc,
    input  logic [31:0] i_mem_rdt,
    input  logic        i_mem_ack,
    output logic        o_err
);

    localparam master_t LAST_RST = DBUS_FIRST ? M_IBUS : M_DBUS;

    state_t      r_state;
    state_t      w_next;
    master_t     r_last;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_busy;
    logic        w_done;
    logic        w_tmo_exp;
    logic [31:0] w_rdata;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = DBUS;
                end else if (w_grant_i) begin
                    w_next = IBUS;
                end
            end
            IBUS, DBUS: begin
                if (w_done) begin
                    w_next = HOLD;
                end
            end
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Contention goes to whichever master was not served last.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE) begin
            if (i_dbus_cyc && (!i_ibus_cyc || (r_last == M_IBUS))) begin
                w_grant_d = 1'b1;
            end else if (i_ibus_cyc) begin
                w_grant_i = 1'b1;
            end
        end
        w_busy  = (r_state == IBUS) || (r_state == DBUS);
        w_done  = w_busy && (i_mem_ack || w_tmo_exp);
        w_rdata = i_mem_ack ? i_mem_rdt : ERR_RDATA;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last     <= LAST_RST;
            o_mem_adr  <= '0;
            o_mem_dat  <= '0;
            o_mem_sel  <= '0;
            o_mem_we   <= 1'b0;
            o_mem_cyc  <= 1'b0;
            o_ibus_rdt <= '0;
            o_ibus_ack <= 1'b0;
            o_dbus_rdt <= '0;
            o_dbus_ack <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
            o_err      <= 1'b0;
            if (w_grant_d) begin
                r_last    <= M_DBUS;
                o_mem_adr <= i_dbus_adr;
                o_mem_dat <= i_dbus_dat;
                o_mem_sel <= i_dbus_sel;
                o_mem_we  <= i_dbus_we;
                o_mem_cyc <= 1'b1;
            end else if (w_grant_i) begin
                r_last    <= M_IBUS;
                o_mem_adr <= i_ibus_adr;
                o_mem_dat <= '0;
                o_mem_sel <= 4'hF;
                o_mem_we  <= 1'b0;
                o_mem_cyc <= 1'b1;
            end
            if (w_done) begin
                o_mem_cyc <= 1'b0;
                o_err     <= !i_mem_ack;
                if (r_state == IBUS) begin
                    o_ibus_ack <= 1'b1;
                    o_ibus_rdt <= w_rdata;
                end else begin
                    o_dbus_ack <= 1'b1;
                    o_dbus_rdt <= w_rdata;
                end
            end
        end
    end

    generate
        if (TMO_W > 0) begin : g_tmo
            serv_arb_timeout #(
                .W(TMO_W)
            ) u_tmo (
                .clk      (clk),
                .i_rst_n  (i_rst_n),
                .i_clr    (w_grant_i || w_grant_d),
                .i_en     (w_busy && !i_mem_ack),
                .o_expired(w_tmo_exp)
            );
        end else begin : g_no_tmo
            assign w_tmo_exp = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// tb/tb_serv_mem_arbiter.sv - directed self-checking bench for serv_mem_arbiter
module tb_serv_mem_arbiter;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_dat;
    logic [3:0]  o_mem_sel;
    logic        o_mem_we;
    logic        o_mem_cyc;
    logic [31:0] i_mem_rdt;
    logic        i_mem_ack;
    logic        o_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serv_mem_arbiter #(
        .TMO_W     (4),
        .DBUS_FIRST(1'b1)
    ) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_ibus_adr(i_ibus_adr),
        .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt),
        .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr),
        .i_dbus_dat(i_dbus_dat),
        .i_dbus_sel(i_dbus_sel),
        .i_dbus_we (i_dbus_we),
        .i_dbus_cyc(i_dbus_cyc),
        .o_dbus_rdt(o_dbus_rdt),
        .o_dbus_ack(o_dbus_ack),
        .o_mem_adr (o_mem_adr),
        .o_mem_dat (o_mem_dat),
        .o_mem_sel (o_mem_sel),
        .o_mem_we  (o_mem_we),
        .o_mem_cyc (o_mem_cyc),
        .i_mem_rdt (i_mem_rdt),
        .i_mem_ack (i_mem_ack),
        .o_err     (o_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_rst_n    = 1'b0;
        i_ibus_adr = '0;
        i_ibus_cyc = 1'b0;
        i_dbus_adr = '0;
        i_dbus_dat = '0;
        i_dbus_sel = '0;
        i_dbus_we  = 1'b0;
        i_dbus_cyc = 1'b0;
        i_mem_rdt  = '0;
        i_mem_ack  = 1'b0;
        tick();
        tick();
        check("rst_mem_cyc",  32'(o_mem_cyc), 0);
        check("rst_mem_adr",  o_mem_adr, 0);
        check("rst_mem_sel",  32'(o_mem_sel), 0);
        check("rst_acks_err", 32'({o_ibus_ack, o_dbus_ack, o_err}), 0);
        i_rst_n = 1'b1;
        tick();

        // ibus only, memory acks in the second cycle of o_mem_cyc
        i_ibus_adr = 32'h100;
        i_ibus_cyc = 1'b1;
        tick();
        check("t1_cyc_n1", 32'(o_mem_cyc), 1);
        check("t1_adr",    o_mem_adr, 32'h100);
        check("t1_sel",    32'(o_mem_sel), 32'hF);
        check("t1_we",     32'(o_mem_we), 0);
        tick();
        check("t1_cyc_n2", 32'(o_mem_cyc), 1);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'hDEADBEEF;
        tick();
        i_mem_ack = 1'b0;
        check("t1_ack",      32'(o_ibus_ack), 1);
        check("t1_rdt",      o_ibus_rdt, 32'hDEADBEEF);
        check("t1_cyc_drop", 32'(o_mem_cyc), 0);
        check("t1_no_dack",  32'(o_dbus_ack), 0);
        i_ibus_cyc = 1'b0;
        tick();
        check("t1_ack_once", 32'(o_ibus_ack), 0);

        // simultaneous requests after reset: dbus first, then alternation
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n    = 1'b1;
        i_ibus_adr = 32'h40;
        i_dbus_adr = 32'h3000;
        i_dbus_sel = 4'hF;
        i_ibus_cyc = 1'b1;
        i_dbus_cyc = 1'b1;
        tick();
        check("t2_g1_cyc", 32'(o_mem_cyc), 1);
        check("t2_g1_adr", o_mem_adr, 32'h3000);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h1111_1111;
        tick();
        i_mem_ack = 1'b0;
        check("t2_g1_dack", 32'(o_dbus_ack), 1);
        check("t2_g1_drdt", o_dbus_rdt, 32'h1111_1111);
        check("t2_g1_iack", 32'(o_ibus_ack), 0);
        i_dbus_adr = 32'h3004;
        tick();
        check("t2_idle_cyc", 32'(o_mem_cyc), 0);
        tick();
        check("t2_g2_adr", o_mem_adr, 32'h40);
        check("t2_g2_cyc", 32'(o_mem_cyc), 1);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h2222_2222;
        tick();
        i_mem_ack = 1'b0;
        check("t2_g2_iack", 32'(o_ibus_ack), 1);
        check("t2_g2_irdt", o_ibus_rdt, 32'h2222_2222);
        check("t2_g2_dack", 32'(o_dbus_ack), 0);
        i_ibus_adr = 32'h44;
        tick();
        tick();
        check("t2_g3_adr", o_mem_adr, 32'h3004);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h3333_3333;
        tick();
        i_mem_ack = 1'b0;
        check("t2_g3_dack", 32'(o_dbus_ack), 1);
        check("t2_g3_drdt", o_dbus_rdt, 32'h3333_3333);
        i_dbus_cyc = 1'b0;
        tick();
        tick();
        check("t2_g4_adr", o_mem_adr, 32'h44);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h4444_4444;
        tick();
        i_mem_ack = 1'b0;
        check("t2_g4_iack", 32'(o_ibus_ack), 1);
        check("t2_g4_irdt", o_ibus_rdt, 32'h4444_4444);
        i_ibus_cyc = 1'b0;
        tick();

        // dbus write while ibus waits throughout
        i_dbus_adr = 32'h2000;
        i_dbus_dat = 32'h12345678;
        i_dbus_sel = 4'b0011;
        i_dbus_we  = 1'b1;
        i_ibus_adr = 32'h80;
        i_dbus_cyc = 1'b1;
        i_ibus_cyc = 1'b1;
        tick();
        check("t3_dat", o_mem_dat, 32'h12345678);
        check("t3_sel", 32'(o_mem_sel), 32'h3);
        check("t3_we",  32'(o_mem_we), 1);
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_adr", o_mem_adr, 32'h2000);
            tick();
        end
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h5555_5555;
        tick();
        i_mem_ack = 1'b0;
        check("t3_dack",     32'(o_dbus_ack), 1);
        check("t3_no_iack",  32'(o_ibus_ack), 0);
        check("t3_hold_cyc", 32'(o_mem_cyc), 0);
        i_dbus_cyc = 1'b0;
        i_dbus_we  = 1'b0;
        tick();
        check("t3_idle_cyc", 32'(o_mem_cyc), 0);
        tick();
        check("t3_i_adr", o_mem_adr, 32'h80);
        check("t3_i_sel", 32'(o_mem_sel), 32'hF);
        check("t3_i_we",  32'(o_mem_we), 0);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h6666_6666;
        tick();
        check("t3_iack", 32'(o_ibus_ack), 1);
        check("t3_irdt", o_ibus_rdt, 32'h6666_6666);
        i_ibus_cyc = 1'b0;

        // stray memory acks in HOLD and IDLE
        i_mem_rdt = 32'hBAD0_BAD0;
        tick();
        check("t6_hold_acks", 32'({o_ibus_ack, o_dbus_ack}), 0);
        check("t6_hold_irdt", o_ibus_rdt, 32'h6666_6666);
        check("t6_hold_cyc",  32'(o_mem_cyc), 0);
        tick();
        check("t6_idle_acks", 32'({o_ibus_ack, o_dbus_ack, o_err}), 0);
        check("t6_idle_drdt", o_dbus_rdt, 32'h5555_5555);
        check("t6_idle_irdt", o_ibus_rdt, 32'h6666_6666);
        i_mem_ack  = 1'b0;
        i_ibus_adr = 32'h90;
        i_ibus_cyc = 1'b1;
        tick();
        check("t6_state_cyc", 32'(o_mem_cyc), 1);
        check("t6_state_adr", o_mem_adr, 32'h90);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h7777_7777;
        tick();
        i_mem_ack = 1'b0;
        check("t6_iack", 32'(o_ibus_ack), 1);
        i_ibus_cyc = 1'b0;
        tick();

        // timeout with TMO_W=4: fifteen cycles of o_mem_cyc, then error ack
        i_ibus_adr = 32'hA0;
        i_ibus_cyc = 1'b1;
        n = 0;
        tick();
        while (o_mem_cyc === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("t4_cyc_cycles", n, 15);
        check("t4_iack", 32'(o_ibus_ack), 1);
        check("t4_err",  32'(o_err), 1);
        check("t4_rdt",  o_ibus_rdt, 32'hFFFF_FFFF);
        i_ibus_cyc = 1'b0;
        tick();
        check("t4_err_pulse", 32'({o_err, o_ibus_ack}), 0);
        i_ibus_adr = 32'hB0;
        i_ibus_cyc = 1'b1;
        tick();
        repeat (14) tick();
        check("t4b_cyc_15", 32'(o_mem_cyc), 1);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h8888_8888;
        tick();
        i_mem_ack = 1'b0;
        check("t4b_iack",   32'(o_ibus_ack), 1);
        check("t4b_no_err", 32'(o_err), 0);
        check("t4b_rdt",    o_ibus_rdt, 32'h8888_8888);
        i_ibus_cyc = 1'b0;
        tick();

        // asynchronous reset in the middle of a dbus transaction
        i_dbus_adr = 32'hC0;
        i_dbus_sel = 4'hF;
        i_ibus_adr = 32'hD0;
        i_dbus_cyc = 1'b1;
        i_ibus_cyc = 1'b1;
        tick();
        check("t5_pre_adr", o_mem_adr, 32'hC0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_cyc",  32'(o_mem_cyc), 0);
        check("t5_rst_adr",  o_mem_adr, 0);
        check("t5_rst_sel",  32'(o_mem_sel), 0);
        check("t5_rst_irdt", o_ibus_rdt, 0);
        i_dbus_cyc = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        check("t5_regrant_cyc", 32'(o_mem_cyc), 1);
        check("t5_regrant_adr", o_mem_adr, 32'hD0);
        i_mem_ack = 1'b1;
        i_mem_rdt = 32'h9999_9999;
        tick();
        i_mem_ack = 1'b0;
        check("t5_iack", 32'(o_ibus_ack), 1);
        check("t5_irdt", o_ibus_rdt, 32'h9999_9999);
        i_ibus_cyc = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
